// File: rtl/mesm6_pkg.sv
// mesm6_pkg: definitions shared by the MESM-6 instruction fetch cache.
//   fetch_state_t     : fetch FSM states (FS_PREFETCH is only entered when the
//                       cache is built with MESM6_FETCH_PREFETCH_EN)
//   MESM6_AW/MESM6_WW : default word-address and instruction-word widths
//   idx_w()           : index width for a table of n entries (at least 1 bit)
package mesm6_pkg;

  localparam int MESM6_AW = 15;
  localparam int MESM6_WW = 48;

  typedef enum logic [1:0] {
    FS_IDLE     = 2'd0,
    FS_FILL     = 2'd1,
    FS_PREFETCH = 2'd2
  } fetch_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mesm6_tag_cam.sv
// mesm6_tag_cam: fully associative, purely combinational tag match.
// Ports:
//   tags_i  : tag of every entry
//   valid_i : valid bit of every entry
//   addr_i  : word address being looked up
//   hit_o   : some valid entry holds addr_i
//   idx_o   : index of the matching entry (0 when there is no hit)
// The cache never holds the same tag twice, so at most one entry matches.
module mesm6_tag_cam
  import mesm6_pkg::*;
#(
  parameter  int ENTRIES = 4,
  parameter  int TW      = MESM6_AW,
  localparam int IW      = idx_w(ENTRIES)
) (
  input  logic [ENTRIES-1:0][TW-1:0] tags_i,
  input  logic [ENTRIES-1:0]         valid_i,
  input  logic [TW-1:0]              addr_i,
  output logic                       hit_o,
  output logic [IW-1:0]              idx_o
);

  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_i[i] && (tags_i[i] == addr_i)) begin
        hit_o = 1'b1;
        idx_o = IW'(i);
      end
    end
  end

endmodule

// File: rtl/mesm6_fetch_cache.sv
// mesm6_fetch_cache: small fully associative instruction-word cache sitting
// between the MESM-6 core fetch port and the instruction bus.
// Ports:
//   clk, reset        : clock; synchronous active-high reset
//   flush             : invalidate every entry (cancels an outstanding fill)
//   cpu_req, cpu_pc   : opcode request at half-word PC (bit 0 picks the half)
//   cpu_ready         : cpu_opcode is valid this cycle (zero-cycle hit)
//   cpu_opcode        : selected half of the cached word
//   ibus_fetch        : word fetch outstanding on the bus
//   ibus_addr         : word address of the outstanding fetch
//   ibus_input        : fetched word, qualified by ibus_done
//   ibus_done         : fetch complete
//   stat_miss         : one-cycle pulse per demand miss
// Build option: define MESM6_FETCH_PREFETCH_EN to fetch word W+1 into the next
// replacement slot after every demand fill of word W (when W+1 is absent).
// Replacement is round-robin through a single victim pointer.
module mesm6_fetch_cache
  import mesm6_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int AW      = MESM6_AW,
  parameter int WW      = MESM6_WW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          cpu_req,
  input  logic [AW:0]   cpu_pc,
  output logic          cpu_ready,
  output logic [WW/2-1:0] cpu_opcode,
  output logic          ibus_fetch,
  output logic [AW-1:0] ibus_addr,
  input  logic [WW-1:0] ibus_input,
  input  logic          ibus_done,
  output logic          stat_miss
);

  localparam int IW = idx_w(ENTRIES);
  localparam int HW = WW / 2;

  fetch_state_t                 state_q;
  logic [ENTRIES-1:0]           valid_q;
  logic [ENTRIES-1:0][AW-1:0]   tag_q;
  logic [ENTRIES-1:0][WW-1:0]   data_q;
  logic [IW-1:0]                victim_q;
  logic [IW-1:0]                victim_d;
  logic [AW-1:0]                addr_q;
  logic                         stat_miss_q;

  logic [AW-1:0] lookup;
  logic          hit;
  logic [IW-1:0] hit_idx;
  logic [WW-1:0] hit_word;
  logic          fill_done;

  assign lookup = cpu_pc[AW:1];

  mesm6_tag_cam #(
    .ENTRIES (ENTRIES),
    .TW      (AW)
  ) u_cam (
    .tags_i  (tag_q),
    .valid_i (valid_q),
    .addr_i  (lookup),
    .hit_o   (hit),
    .idx_o   (hit_idx)
  );

  assign hit_word   = data_q[hit_idx];
  assign cpu_ready  = cpu_req & hit & ~flush;
  // Even half-word addresses hold the upper half of the instruction word.
  assign cpu_opcode = cpu_pc[0] ? hit_word[HW-1:0] : hit_word[WW-1:HW];
  assign ibus_fetch = (state_q != FS_IDLE);
  assign ibus_addr  = addr_q;
  assign stat_miss  = stat_miss_q;

  // Bus data is taken only while a fetch is outstanding and no flush cancels it.
  assign fill_done  = ibus_fetch & ibus_done & ~flush;
  assign victim_d   = (victim_q == IW'(ENTRIES - 1)) ? '0 : victim_q + IW'(1);

`ifdef MESM6_FETCH_PREFETCH_EN
  logic [AW-1:0] next_addr;
  logic          next_resident;

  assign next_addr = addr_q + AW'(1);

  // The slot being overwritten by the current fill does not count as holding W+1.
  always_comb begin
    next_resident = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && (tag_q[i] == next_addr) && (IW'(i) != victim_q))
        next_resident = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FS_IDLE;
      valid_q     <= '0;
      victim_q    <= '0;
      stat_miss_q <= 1'b0;
    end else begin
      stat_miss_q <= 1'b0;
      if (flush)
        valid_q <= '0;
      else if (fill_done)
        valid_q[victim_q] <= 1'b1;
      if (fill_done)
        victim_q <= victim_d;

      case (state_q)
        FS_IDLE: begin
          if (cpu_req && !hit && !flush) begin
            state_q     <= FS_FILL;
            stat_miss_q <= 1'b1;
          end
        end
        FS_FILL: begin
          if (flush) begin
            state_q <= FS_IDLE;
          end else if (ibus_done) begin
`ifdef MESM6_FETCH_PREFETCH_EN
            if ((ENTRIES > 1) && !next_resident)
              state_q <= FS_PREFETCH;
            else
              state_q <= FS_IDLE;
`else
            state_q <= FS_IDLE;
`endif
          end
        end
        default: begin
          if (flush || ibus_done)
            state_q <= FS_IDLE;
        end
      endcase
    end
  end

  // Tags, data and the fetch address carry no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_q[victim_q]  <= addr_q;
      data_q[victim_q] <= ibus_input;
    end
    if ((state_q == FS_IDLE) && cpu_req && !hit)
      addr_q <= lookup;
`ifdef MESM6_FETCH_PREFETCH_EN
    else if ((state_q == FS_FILL) && ibus_done)
      addr_q <= next_addr;
`endif
  end

endmodule

// File: tb/tb_mesm6_fetch_cache.sv
// tb_mesm6_fetch_cache: directed bench for mesm6_fetch_cache (ENTRIES=4,
// AW=15, WW=48). Expected opcodes and bus addresses are queued when a request
// is driven and popped when the cache answers. With MESM6_FETCH_PREFETCH_EN
// defined the prefetch wrap scenario runs instead of the demand-only ones.
module tb_mesm6_fetch_cache;

  localparam int AW = 15;
  localparam int WW = 48;
  localparam int HW = WW / 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          cpu_req;
  logic [AW:0]   cpu_pc;
  logic          cpu_ready;
  logic [HW-1:0] cpu_opcode;
  logic          ibus_fetch;
  logic [AW-1:0] ibus_addr;
  logic [WW-1:0] ibus_input;
  logic          ibus_done;
  logic          stat_miss;

  int checks   = 0;
  int errors   = 0;
  int miss_cnt = 0;
  int xfer_cnt = 0;

  logic [HW-1:0] exp_op_q[$];
  logic [AW-1:0] exp_addr_q[$];

  always #5 clk = ~clk;

  mesm6_fetch_cache #(
    .ENTRIES (4),
    .AW      (AW),
    .WW      (WW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .cpu_req    (cpu_req),
    .cpu_pc     (cpu_pc),
    .cpu_ready  (cpu_ready),
    .cpu_opcode (cpu_opcode),
    .ibus_fetch (ibus_fetch),
    .ibus_addr  (ibus_addr),
    .ibus_input (ibus_input),
    .ibus_done  (ibus_done),
    .stat_miss  (stat_miss)
  );

  // stat_miss only changes on the rising edge, so the falling edge is a safe sample point.
  always @(negedge clk) if (!reset && stat_miss) miss_cnt++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // Memory image seen through the bus.
  function automatic logic [WW-1:0] word_of(input logic [AW-1:0] a);
    if (a == 15'h0008) return 48'hAAAAAA555555;
    return {9'h0A5, a, 9'h15A, a};
  endfunction

  function automatic logic [HW-1:0] half_of(input logic [AW:0] pc);
    logic [WW-1:0] w;
    w = word_of(pc[AW:1]);
    return pc[0] ? w[HW-1:0] : w[WW-1:HW];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_op(input string tag);
    if (exp_op_q.size() > 0) begin
      chk(tag, 64'(cpu_opcode), 64'(exp_op_q.pop_front()));
    end else begin
      checks++;
      errors++;
      $error("FAIL %s: observed opcode 0x%0h expected a queued opcode (queue empty)", tag, cpu_opcode);
    end
  endtask

  // Waits (bounded) for a bus fetch, checks its address against the queue,
  // holds it for lat cycles, then returns the word. Ends one cycle after done.
  task automatic bus_serve(input int lat);
    logic [AW-1:0] a;
    int c;
    c = 0;
    while (!ibus_fetch && c < 20) begin
      @(negedge clk);
      #1;
      c++;
    end
    if (!ibus_fetch || exp_addr_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL bus_wait: observed fetch=%0b queued=%0d expected fetch=1 with an address queued",
             ibus_fetch, exp_addr_q.size());
      return;
    end
    a = exp_addr_q.pop_front();
    chk("ibus_addr", 64'(ibus_addr), 64'(a));
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      #1;
      chk("ibus_hold", 64'({ibus_fetch, ibus_addr}), 64'({1'b1, a}));
    end
    @(negedge clk);
    ibus_done  = 1'b1;
    ibus_input = word_of(a);
    xfer_cnt++;
    @(negedge clk);
    ibus_done  = 1'b0;
    ibus_input = '0;
    #1;
  endtask

  task automatic fetch_op(input logic [AW:0] pc, input bit miss);
    int m0;
    @(negedge clk);
    cpu_req = 1'b1;
    cpu_pc  = pc;
    #1;
    m0 = miss_cnt;
    exp_op_q.push_back(half_of(pc));
    if (miss) begin
      chk("miss_not_ready", 64'(cpu_ready), 64'd0);
      exp_addr_q.push_back(pc[AW:1]);
      bus_serve(2);
      chk("miss_pulses", 64'(miss_cnt - m0), 64'd1);
    end else begin
      chk("hit_no_fetch", 64'(ibus_fetch), 64'd0);
    end
    chk("ready", 64'(cpu_ready), 64'd1);
    expect_op("opcode");
    cpu_req = 1'b0;
  endtask

  initial begin
    int m;
    reset      = 1'b1;
    flush      = 1'b0;
    cpu_req    = 1'b1;
    cpu_pc     = 16'h0010;
    ibus_input = '0;
    ibus_done  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ready", 64'(cpu_ready), 64'd0);
    chk("reset_fetch", 64'(ibus_fetch), 64'd0);
    chk("reset_miss", 64'(stat_miss), 64'd0);
    @(negedge clk);
    reset   = 1'b0;
    cpu_req = 1'b0;

`ifdef MESM6_FETCH_PREFETCH_EN
    // Demand miss on the last word, then the prefetch wraps to word 0.
    fetch_op(16'hFFFE, 1'b1);
    exp_addr_q.push_back(15'h0000);
    bus_serve(2);
    fetch_op(16'h0000, 1'b0);
    fetch_op(16'h0001, 1'b0);
    chk("prefetch_miss_total", 64'(miss_cnt), 64'd1);
    chk("prefetch_xfers", 64'(xfer_cnt), 64'd2);
`else
    // First miss, both halves of word 8.
    fetch_op(16'h0010, 1'b1);
    fetch_op(16'h0011, 1'b0);
    chk("one_bus_fetch", 64'(xfer_cnt), 64'd1);

    // Flush suppresses a hit in its own cycle and drops the entry.
    @(negedge clk);
    flush   = 1'b1;
    cpu_req = 1'b1;
    cpu_pc  = 16'h0010;
    #1;
    chk("flush_suppress", 64'(cpu_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flushed_word", 64'(cpu_ready), 64'd0);
    cpu_req = 1'b0;

    // Five words through four entries: word 1 is replaced by word 5.
    for (int w = 1; w <= 5; w++) fetch_op({AW'(w), 1'b0}, 1'b1);
    for (int w = 2; w <= 5; w++) fetch_op({AW'(w), 1'b1}, 1'b0);
    fetch_op(16'h0002, 1'b1);

    // Flush coincident with ibus_done discards the fill.
    @(negedge clk);
    cpu_req = 1'b1;
    cpu_pc  = 16'h0060;
    #1;
    @(negedge clk);
    #1;
    chk("fd_fetch", 64'({ibus_fetch, ibus_addr}), 64'({1'b1, 15'h0030}));
    @(negedge clk);
    ibus_done  = 1'b1;
    ibus_input = word_of(15'h0030);
    flush      = 1'b1;
    cpu_pc     = 16'h0008;
    #1;
    chk("fd_suppress", 64'(cpu_ready), 64'd0);
    @(negedge clk);
    ibus_done = 1'b0;
    flush     = 1'b0;
    cpu_req   = 1'b0;
    #1;
    chk("fd_idle", 64'(ibus_fetch), 64'd0);
    fetch_op(16'h0060, 1'b1);
    fetch_op(16'h0008, 1'b1);

    // PC moves mid-fill: the old fill completes, then the new word misses.
    m = miss_cnt;
    @(negedge clk);
    cpu_req = 1'b1;
    cpu_pc  = 16'h0020;
    #1;
    exp_addr_q.push_back(15'h0010);
    @(negedge clk);
    cpu_pc = 16'h0040;
    #1;
    bus_serve(2);
    chk("pcchg_not_ready", 64'(cpu_ready), 64'd0);
    exp_addr_q.push_back(15'h0020);
    exp_op_q.push_back(half_of(16'h0040));
    bus_serve(2);
    chk("pcchg_ready", 64'(cpu_ready), 64'd1);
    expect_op("pcchg_opcode");
    chk("pcchg_misses", 64'(miss_cnt - m), 64'd2);
    cpu_req = 1'b0;
    fetch_op(16'h0021, 1'b0);

    // Reset in the middle of a fill; the late ibus_done must be ignored.
    @(negedge clk);
    cpu_req = 1'b1;
    cpu_pc  = 16'h0100;
    #1;
    @(negedge clk);
    #1;
    chk("rst_fetch_on", 64'(ibus_fetch), 64'd1);
    @(negedge clk);
    reset   = 1'b1;
    cpu_req = 1'b0;
    #1;
    @(negedge clk);
    reset      = 1'b0;
    ibus_done  = 1'b1;
    ibus_input = word_of(15'h0080);
    #1;
    chk("rst_fetch_off", 64'(ibus_fetch), 64'd0);
    @(negedge clk);
    ibus_done = 1'b0;
    cpu_req   = 1'b1;
    cpu_pc    = 16'h0100;
    #1;
    chk("rst_no_fill", 64'(cpu_ready), 64'd0);
    cpu_pc = 16'h0021;
    #1;
    chk("rst_cleared", 64'(cpu_ready), 64'd0);
    chk("rst_fetch_after", 64'(ibus_fetch), 64'd0);
    cpu_req = 1'b0;
`endif

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
